// File: rtl/mul_accumulator_if.sv
// rtl/mul_accumulator_if.sv - product input stream and result output stream of the MAC stage
interface mul_accumulator_if #(
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_product;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_sum;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_overflow;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/mul_accumulator.sv
// rtl/mul_accumulator.sv - accumulates signed 8-bit products into a series sum with sticky overflow
module mul_accumulator #(
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 8,
  parameter int SATURATE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  mul_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [COUNT_WIDTH-1:0] count;
  logic                   overflow;

  logic                   out_valid_r;
  logic [ACC_WIDTH-1:0]   out_sum_r;
  logic [COUNT_WIDTH-1:0] out_count_r;
  logic                   out_overflow_r;

  logic [ACC_WIDTH-1:0]   addend;
  logic [ACC_WIDTH-1:0]   sum;
  logic [ACC_WIDTH-1:0]   next_acc;
  logic [COUNT_WIDTH-1:0] next_count;
  logic                   add_ovf;
  logic                   next_ovf;
  logic                   accept;

  assign bus.in_ready     = (state == ACCUM) && !rst;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_sum      = out_sum_r;
  assign bus.out_count    = out_count_r;
  assign bus.out_overflow = out_overflow_r;

  assign accept = bus.in_valid && bus.in_ready;

  // Overflow only possible when both addends share a sign and the result flips it.
  always_comb begin
    addend     = {{(ACC_WIDTH-8){bus.in_product[7]}}, bus.in_product};
    sum        = acc + addend;
    add_ovf    = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    next_acc   = sum;
    if (add_ovf && (SATURATE != 0)) begin
      next_acc = addend[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
    next_count = (&count) ? count : count + 1'b1;
    next_ovf   = overflow | add_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCUM;
      acc            <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      out_valid_r    <= 1'b0;
      out_sum_r      <= '0;
      out_count_r    <= '0;
      out_overflow_r <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc      <= next_acc;
            count    <= next_count;
            overflow <= next_ovf;
            if (bus.in_last) begin
              state          <= HOLD;
              out_valid_r    <= 1'b1;
              out_sum_r      <= next_acc;
              out_count_r    <= next_count;
              out_overflow_r <= next_ovf;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state          <= ACCUM;
            acc            <= '0;
            count          <= '0;
            overflow       <= 1'b0;
            out_valid_r    <= 1'b0;
            out_sum_r      <= '0;
            out_count_r    <= '0;
            out_overflow_r <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb/tb_mul_accumulator.sv - directed vector bench for saturating and wrapping accumulators
module tb_mul_accumulator;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_accumulator_if #(.ACC_WIDTH(16), .COUNT_WIDTH(8)) bus_s ();
  mul_accumulator_if #(.ACC_WIDTH(16), .COUNT_WIDTH(8)) bus_w ();

  mul_accumulator #(.ACC_WIDTH(16), .COUNT_WIDTH(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .bus(bus_s.slave)
  );
  mul_accumulator #(.ACC_WIDTH(16), .COUNT_WIDTH(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .bus(bus_w.slave)
  );

  // Both instances see identical stimulus.
  assign bus_w.in_valid   = bus_s.in_valid;
  assign bus_w.in_product = bus_s.in_product;
  assign bus_w.in_last    = bus_s.in_last;
  assign bus_w.out_ready  = bus_s.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] p;
    int              n;
    logic [15:0]     sum;
    logic [7:0]      count;
    logic            ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] p, input logic l);
    int waited;
    waited = 0;
    bus_s.in_valid   = 1'b1;
    bus_s.in_product = p;
    bus_s.in_last    = l;
    @(negedge clk);
    while (!bus_s.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_s.in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus_s.in_valid = 1'b0;
    bus_s.in_last  = 1'b0;
  endtask

  task automatic handshake(input string name);
    bus_s.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_s.out_ready = 1'b0;
    @(negedge clk);
    check({name, "_valid_drop"}, {31'd0, bus_s.out_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, bus_s.in_ready}, 32'd1);
    check({name, "_ovf_clear"}, {31'd0, bus_s.out_overflow}, 32'd0);
  endtask

  task automatic check_result(input string name, input logic [15:0] s_sum, input logic [15:0] w_sum,
                              input logic [7:0] cnt, input logic ovf);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, bus_s.out_valid}, 32'd1);
    check({name, "_sum_sat"}, {16'd0, bus_s.out_sum}, {16'd0, s_sum});
    check({name, "_sum_wrap"}, {16'd0, bus_w.out_sum}, {16'd0, w_sum});
    check({name, "_count"}, {24'd0, bus_s.out_count}, {24'd0, cnt});
    check({name, "_ovf_sat"}, {31'd0, bus_s.out_overflow}, {31'd0, ovf});
    check({name, "_ovf_wrap"}, {31'd0, bus_w.out_overflow}, {31'd0, ovf});
  endtask

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{p: {8'h00, 8'h0F, 8'hFC, 8'h06}, n: 3, sum: 16'h0011, count: 8'd3, ovf: 1'b0};
    vecs[1] = '{p: {8'h00, 8'h00, 8'h00, 8'hF1}, n: 1, sum: 16'hFFF1, count: 8'd1, ovf: 1'b0};
    vecs[2] = '{p: {8'h01, 8'h80, 8'h7F, 8'h7F}, n: 4, sum: 16'h007F, count: 8'd4, ovf: 1'b0};
    vecs[3] = '{p: {8'h00, 8'hFF, 8'h80, 8'h80}, n: 4, sum: 16'hFEFF, count: 8'd4, ovf: 1'b0};
    vecs[4] = '{p: {8'h00, 8'h00, 8'h00, 8'h00}, n: 2, sum: 16'h0000, count: 8'd2, ovf: 1'b0};

    rst              = 1'b1;
    bus_s.in_valid   = 1'b0;
    bus_s.in_product = 8'h00;
    bus_s.in_last    = 1'b0;
    bus_s.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus_s.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus_s.out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, bus_s.out_sum}, 32'd0);
    check("rst_out_count", {24'd0, bus_s.out_count}, 32'd0);
    check("rst_out_ovf", {31'd0, bus_s.out_overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus_s.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].n; b++) begin
        beat(vecs[v].p[b], b == vecs[v].n - 1);
      end
      check_result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].sum, vecs[v].count, vecs[v].ovf);
      handshake($sformatf("vec%0d", v));
      @(posedge clk);
      #1;
    end

    // 259 x 127 = 32893 exceeds +32767
    for (int i = 0; i < 259; i++) beat(8'h7F, i == 258);
    check_result("pos_sat", 16'h7FFF, 16'h807D, 8'hFF, 1'b1);
    handshake("pos_sat");
    @(posedge clk);
    #1;

    for (int i = 0; i < 257; i++) beat(8'h80, 1'b0);
    beat(8'h01, 1'b1);
    check_result("neg_sat", 16'h8001, 16'h7F81, 8'hFF, 1'b1);
    handshake("neg_sat");
    @(posedge clk);
    #1;

    // Backpressure: HOLD ignores in_valid while out_ready is low
    beat(8'h05, 1'b1);
    bus_s.in_valid   = 1'b1;
    bus_s.in_product = 8'h22;
    bus_s.in_last    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_in_ready", c), {31'd0, bus_s.in_ready}, 32'd0);
      check($sformatf("bp%0d_valid", c), {31'd0, bus_s.out_valid}, 32'd1);
      check($sformatf("bp%0d_sum", c), {16'd0, bus_s.out_sum}, 32'h0005);
      check($sformatf("bp%0d_count", c), {24'd0, bus_s.out_count}, 32'd1);
    end
    bus_s.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_s.out_ready = 1'b0;
    bus_s.in_valid  = 1'b0;
    bus_s.in_last   = 1'b0;
    @(negedge clk);
    check("bp_valid_drop", {31'd0, bus_s.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    beat(8'h01, 1'b1);
    check_result("bp_next", 16'h0001, 16'h0001, 8'd1, 1'b0);
    handshake("bp_next");
    @(posedge clk);
    #1;

    // Reset mid-series discards the partial sum
    beat(8'h10, 1'b0);
    beat(8'h10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'd0, bus_s.in_ready}, 32'd0);
    check("abort_valid_a", {31'd0, bus_s.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid_b", {31'd0, bus_s.out_valid}, 32'd0);
    check("abort_sum", {16'd0, bus_s.out_sum}, 32'd0);
    @(posedge clk);
    #1;
    beat(8'h03, 1'b1);
    check_result("abort_next", 16'h0003, 16'h0003, 8'd1, 1'b0);
    handshake("abort_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_accumulator.md
Name: mul_accumulator

Overview:
- Downstream stage of the 4-bit signed combinational multiplier.
- Consumes its 8-bit two's-complement product one beat at a time over a valid/ready handshake.
- Accumulates a variable-length series of products, terminated by in_last, into a sign-extended accumulator.
- Presents the finished sum, term count and overflow flag on a registered valid/ready output port (dot-product / MAC building block).

Parameters:
- ACC_WIDTH, 16, accumulator and out_sum width in bits; must be >= 9.
- COUNT_WIDTH, 8, width of the accepted-term counter.
- SATURATE, 1, 1 = clamp on signed overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_product/in_last are valid this cycle.
- in_ready  output  1  block can accept a term this cycle.
- in_product  input  8  signed two's-complement product from the multiplier.
- in_last  input  1  this term ends the current series.
- out_valid  output  1  out_sum/out_count/out_overflow hold a finished result.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_WIDTH  signed accumulated sum.
- out_count  output  COUNT_WIDTH  number of terms accepted in the series.
- out_overflow  output  1  sticky: signed overflow occurred in the series.

Behaviour:
- Reset: rst sampled on the rising edge of clk.
  - State <= ACCUM; acc, count, overflow <= 0.
  - out_valid = 0, out_sum = 0, out_count = 0, out_overflow = 0.
  - in_ready = 0 in any cycle where rst = 1.
- Outputs are driven directly from registers. in_ready is combinational from the state only (never from in_valid or out_ready).
- State ACCUM:
  - in_ready = 1, out_valid = 0.
  - A term is accepted when in_valid && in_ready.
  - On accept, sext8(in_product) is added to acc.
  - count increments and saturates at all-ones (no wrap).
- Overflow:
  - Signed overflow = both addends have the same sign and the sum's sign differs.
  - On overflow, overflow <= 1 (sticky until the series is consumed).
  - SATURATE = 1: acc clamps to 2^(ACC_WIDTH-1)-1 if the addend is positive, else -2^(ACC_WIDTH-1).
  - SATURATE = 0: acc takes the wrapped sum.
  - Once saturated, further same-sign terms keep acc clamped; opposite-sign terms move it normally.
- Accept with in_last = 1: that term is included, then the state goes to HOLD next cycle.
  - Latency: last term accepted in cycle N; out_valid = 1 in cycle N+1, with out_sum/out_count/out_overflow final.
- State HOLD:
  - in_ready = 0, out_valid = 1. Outputs are stable until the handshake; in_valid is ignored.
  - On out_valid && out_ready: acc, count, overflow <= 0 and state <= ACCUM.
  - out_valid drops the next cycle, so one result per handshake.
  - Minimum gap between series is one cycle: in_ready = 1 in the cycle after the output handshake.
- Boundary cases:
  - in_valid without in_last: the series stays open indefinitely; there is no timeout.
  - Single-term series (first beat has in_last): legal; count = 1.
  - Empty series is not expressible; a result always has count >= 1.
  - rst during ACCUM or HOLD discards the partial or pending result immediately, with no output handshake.
- Arithmetic: the addend is always sign-extended from bit 7 of in_product. No unsigned mode.

Test Plan:
- Basic sum: products 0x06, 0xFC (-4), 0x0F with last on the third -> out_valid on the cycle after the third accept; out_sum = 0x0011, out_count = 3, out_overflow = 0.
- Single term: 0xF1 (-15) with in_last -> out_sum = 0xFFF1, out_count = 1. Then out_ready = 1 -> out_valid = 0 and in_ready = 1 the following cycle.
- Positive saturation (SATURATE = 1): 259 beats of 0x7F, last on the final beat -> out_sum = 0x7FFF, out_overflow = 1, out_count = 0xFF (saturated).
  - Same test with SATURATE = 0 -> out_sum = 0x807D (32893 wrapped), out_overflow = 1.
- Negative saturation and recovery: 257 beats of 0x80, then 0x01 with last -> out_sum = 0x8001, out_overflow = 1, out_count = 0xFF.
- Backpressure: hold out_ready = 0 for 5 cycles in HOLD while driving in_valid = 1 with 0x22 -> in_ready = 0 throughout, outputs unchanged, 0x22 not accumulated. After the handshake, the next series starts from 0.
- Reset mid-series: accept 0x10, 0x10, then assert rst for one cycle, then series 0x03 with last -> out_sum = 0x0003, out_count = 1, out_overflow = 0. No out_valid is ever seen for the aborted series.
